// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the raw lines and frames 11-bit words into bytes.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity validation; otherwise only the stop bit decides validity.
module ps2_rx_framer #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] data,
  output logic       data_en,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t       state_q, state_d;
  logic         clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic         filt_q, filt_d;
  logic [3:0]   flt_cnt_q, flt_cnt_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]   data_q, data_d;
  logic         data_en_q, data_en_d;
  logic         frame_err_q, frame_err_d;
  logic         fall, timeout_hit, stop_edge, parity_ok, frame_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  assign parity_ok = ^{shift_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  // The filtered level only moves once FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (flt_cnt_q == 4'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else flt_cnt_d = flt_cnt_q + 4'd1;
    end
  end

  assign fall        = filt_q & ~filt_d;
  assign timeout_hit = (state_q != IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign stop_edge   = (state_q == STOP) && fall;
  assign frame_ok    = dat_s2_q && parity_ok;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif
    if (timeout_hit) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE: if (!dat_s2_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = PARITY;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = dat_s2_q;
`endif
          state_d = STOP;
        end
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (state_q == IDLE || fall || timeout_hit) to_cnt_d = '0;
    else to_cnt_d = to_cnt_q + TW'(1);
  end

  // Stop-edge and timeout are mutually exclusive, so the strobes can never overlap.
  always_comb begin
    data_d      = data_q;
    data_en_d   = 1'b0;
    frame_err_d = 1'b0;
    if (stop_edge) begin
      if (frame_ok) begin
        data_d    = shift_q;
        data_en_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
    end else if (timeout_hit) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      flt_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      data_q      <= '0;
      data_en_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= 1'b0;
`endif
    end else begin
      clk_s1_q    <= PS2_CLK;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= PS2_DAT;
      dat_s2_q    <= dat_s1_q;
      filt_q      <= filt_d;
      flt_cnt_q   <= flt_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      data_q      <= data_d;
      data_en_q   <= data_en_d;
      frame_err_q <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= par_d;
`endif
    end
  end

  assign data      = data_q;
  assign data_en   = data_en_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_framer.sv
// Self-checking bench for ps2_rx_framer: directed scenarios plus random back-to-back frames vs. a frame-level model.
module tb_ps2_rx_framer;
  localparam int unsigned FL   = 4;
  localparam int unsigned TO   = 300;
  localparam int unsigned HALF = 20;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [7:0] data;
  logic       data_en, frame_err;

  ps2_rx_framer #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .Reset(Reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .data(data), .data_en(data_en), .frame_err(frame_err)
  );

  always #5 Clock = ~Clock;

  int vectors = 0, miscompares = 0;
  int en_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [7:0] got_q[$];

  int exp_en = 0, exp_err = 0;
  logic [7:0] exp_data = 8'h00;
  logic [7:0] exp_q[$];

  // Counting high cycles (not edges) makes a stretched strobe show up as an extra count.
  always @(negedge Clock) begin
    if (data_en) begin
      en_cnt++;
      got_q.push_back(data);
    end
    if (frame_err) err_cnt++;
    if (data_en && frame_err) both_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic send_bit(input logic b);
    PS2_DAT = b;
    idle(HALF);
    PS2_CLK = 1'b0;
    idle(HALF);
    PS2_CLK = 1'b1;
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  function automatic bit model_ok(input logic [7:0] b, input logic par, input logic stp);
`ifdef PS2_PARITY_CHECK_EN
    return stp && (($countones({b, par}) % 2) == 1);
`else
    return stp == 1'b1;
`endif
  endfunction

  task automatic model_frame(input logic [7:0] b, input logic par, input logic stp);
    if (model_ok(b, par, stp)) begin
      exp_en++;
      exp_data = b;
      exp_q.push_back(b);
    end else begin
      exp_err++;
    end
  endtask

  task automatic xfer(input logic [7:0] b, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stp);
    model_frame(b, par, stp);
  endtask

  task automatic test_reset();
    idle(3);
    vectors++;
    if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h, required 00", data); end
    vectors++;
    if (data_en !== 1'b0) begin miscompares++; $display("FAIL reset_en: got %b, required 0", data_en); end
    vectors++;
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b, required 0", frame_err); end
    Reset = 1'b0;
    idle(10);
  endtask

  task automatic test_known();
    xfer(8'h1D, 1'b1, 1'b1);
    idle(HALF);
    vectors++;
    if (data !== exp_data || exp_data !== 8'h1D) begin miscompares++; $display("FAIL known_1d_data: got %h, required 1d", data); end
    vectors++;
    if (en_cnt !== exp_en) begin miscompares++; $display("FAIL known_1d_en: got %0d, required %0d", en_cnt, exp_en); end
    vectors++;
    if (err_cnt !== exp_err) begin miscompares++; $display("FAIL known_1d_err: got %0d, required %0d", err_cnt, exp_err); end
  endtask

  task automatic test_parity();
    xfer(8'h5A, ~good_par(8'h5A), 1'b1);
    idle(HALF);
    vectors++;
    if (data !== exp_data) begin miscompares++; $display("FAIL parity_5a_data: got %h, required %h", data, exp_data); end
    vectors++;
    if (en_cnt !== exp_en) begin miscompares++; $display("FAIL parity_5a_en: got %0d, required %0d", en_cnt, exp_en); end
    vectors++;
    if (err_cnt !== exp_err) begin miscompares++; $display("FAIL parity_5a_err: got %0d, required %0d", err_cnt, exp_err); end
  endtask

  task automatic test_stop_err();
    xfer(8'h23, good_par(8'h23), 1'b0);
    idle(HALF);
    vectors++;
    if (data !== exp_data) begin miscompares++; $display("FAIL stop_23_data: got %h, required %h", data, exp_data); end
    vectors++;
    if (en_cnt !== exp_en) begin miscompares++; $display("FAIL stop_23_en: got %0d, required %0d", en_cnt, exp_en); end
    vectors++;
    if (err_cnt !== exp_err) begin miscompares++; $display("FAIL stop_23_err: got %0d, required %0d", err_cnt, exp_err); end
  endtask

  task automatic test_timeout();
    logic [7:0] b = 8'hA5;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(b[i]);
    idle(TO / 2);
    vectors++;
    if (err_cnt !== exp_err) begin miscompares++; $display("FAIL timeout_early: got %0d, required %0d", err_cnt, exp_err); end
    idle(TO);
    exp_err++;
    vectors++;
    if (err_cnt !== exp_err) begin miscompares++; $display("FAIL timeout_err: got %0d, required %0d", err_cnt, exp_err); end
    vectors++;
    if (en_cnt !== exp_en) begin miscompares++; $display("FAIL timeout_en: got %0d, required %0d", en_cnt, exp_en); end
    xfer(8'hF0, good_par(8'hF0), 1'b1);
    idle(HALF);
    vectors++;
    if (data !== 8'hF0) begin miscompares++; $display("FAIL timeout_f0_data: got %h, required f0", data); end
    vectors++;
    if (en_cnt !== exp_en) begin miscompares++; $display("FAIL timeout_f0_en: got %0d, required %0d", en_cnt, exp_en); end
  endtask

  task automatic test_glitch();
    logic [7:0] b = 8'h1B;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        idle(5);
        PS2_CLK = 1'b0;
        idle(FL - 1);
        PS2_CLK = 1'b1;
        idle(5);
      end
      send_bit(b[i]);
    end
    send_bit(good_par(b));
    send_bit(1'b1);
    model_frame(b, good_par(b), 1'b1);
    idle(HALF);
    vectors++;
    if (data !== 8'h1B) begin miscompares++; $display("FAIL glitch_1b_data: got %h, required 1b", data); end
    vectors++;
    if (en_cnt !== exp_en) begin miscompares++; $display("FAIL glitch_1b_en: got %0d, required %0d", en_cnt, exp_en); end
    vectors++;
    if (err_cnt !== exp_err) begin miscompares++; $display("FAIL glitch_1b_err: got %0d, required %0d", err_cnt, exp_err); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    Reset = 1'b1;
    exp_data = 8'h00;
    idle(4);
    vectors++;
    if (data !== 8'h00) begin miscompares++; $display("FAIL rstmid_data: got %h, required 00", data); end
    idle(HALF);
    Reset = 1'b0;
    idle(HALF);
    vectors++;
    if (en_cnt !== exp_en || err_cnt !== exp_err) begin
      miscompares++;
      $display("FAIL rstmid_nostrobe: got en=%0d err=%0d, required en=%0d err=%0d", en_cnt, err_cnt, exp_en, exp_err);
    end
    xfer(b, good_par(b), 1'b1);
    idle(HALF);
    vectors++;
    if (data !== 8'h1C) begin miscompares++; $display("FAIL rstmid_1c_data: got %h, required 1c", data); end
    vectors++;
    if (en_cnt !== exp_en) begin miscompares++; $display("FAIL rstmid_1c_en: got %0d, required %0d", en_cnt, exp_en); end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      logic par, stp;
      b   = 8'($urandom);
      par = ($urandom_range(0, 3) == 0) ? ~good_par(b) : good_par(b);
      stp = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
      xfer(b, par, stp);
    end
    idle(HALF);
    vectors++;
    if (en_cnt !== exp_en) begin miscompares++; $display("FAIL b2b_en: got %0d, required %0d", en_cnt, exp_en); end
    vectors++;
    if (err_cnt !== exp_err) begin miscompares++; $display("FAIL b2b_err: got %0d, required %0d", err_cnt, exp_err); end
    vectors++;
    if (data !== exp_data) begin miscompares++; $display("FAIL b2b_data: got %h, required %h", data, exp_data); end
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d bytes, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL b2b_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (both_cnt !== 0) begin miscompares++; $display("FAIL strobe_overlap: got %0d, required 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_known();
    test_parity();
    test_stop_err();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
